// File: rtl/fill_buff_if.sv
// Handshake bundle for fill_buff: sample input, drain requests and the returned word/status.
// The master side is the sample source and drain requester; the slave side is fill_buff.
interface fill_buff_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 1024
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [DW-1:0]   din;
  logic            din_valid;
  logic            rd_req;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic            buff_full;
  logic [CntW-1:0] wr_cnt;
  logic            overflow;

  modport master (
    output din, din_valid, rd_req,
    input  dout, dout_valid, buff_full, wr_cnt, overflow
  );

  modport slave (
    input  din, din_valid, rd_req,
    output dout, dout_valid, buff_full, wr_cnt, overflow
  );
endinterface

// File: rtl/fill_buff.sv
// Frame buffer: fills DEPTH words from the sample stream, then drains the whole frame
// in write order on request before accepting the next frame.
module fill_buff #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 1024
) (
  input logic        clk,
  input logic        rst_n,
  fill_buff_if.slave bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;
  localparam logic [AW-1:0]   LastAddr = AW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(DEPTH);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic            overflow_q, overflow_d;
  logic            mem_we;

  // Memory is deliberately left out of reset; a discarded partial frame is simply overwritten.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= bus.din;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_cnt_d     = wr_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    mem_we       = 1'b0;

    unique case (state_q)
      StFill: begin
        if (bus.din_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          wr_cnt_d = wr_cnt_q + CntW'(1);
          if (wr_ptr_q == LastAddr) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        // Samples arriving while a frame is held are lost, including on the last-read cycle.
        if (bus.din_valid) begin
          overflow_d = 1'b1;
        end
        if (bus.rd_req) begin
          dout_d       = mem[rd_ptr_q];
          dout_valid_d = 1'b1;
          rd_ptr_d     = rd_ptr_q + AW'(1);
          if (rd_ptr_q == LastAddr) begin
            state_d  = StFill;
            wr_cnt_d = '0;
            wr_ptr_d = '0;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFill;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wr_cnt_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // wr_cnt holds at DEPTH for the whole drain; it is not a fill-level counter.
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.buff_full  = (state_q == StFull);
  assign bus.wr_cnt     = wr_cnt_q;
  assign bus.overflow   = overflow_q;

  logic unused_cnt;
  assign unused_cnt = ^FullCnt;
endmodule

// File: tb/tb_fill_buff.sv
// Directed bench for fill_buff: full fill/drain, overflow, idle reads in FILL,
// reset mid-drain and the din_valid-through-last-read corner.
module tb_fill_buff;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1024;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fill_buff_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  fill_buff #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.rd_req    = 1'b0;
    step();
    step();
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
    check("rst_buff_full", 32'(bus.buff_full), 32'h0);
    check("rst_wr_cnt", 32'(bus.wr_cnt), 32'h0);
    check("rst_overflow", 32'(bus.overflow), 32'h0);
    rst_n = 1'b1;

    // Frame 1: 0x0000..0x03FF, continuous.
    for (int i = 0; i < 1024; i++) begin
      bus.din       = 16'(i);
      bus.din_valid = 1'b1;
      step();
      if (i == 0)    check("fill1_cnt_first", 32'(bus.wr_cnt), 32'd1);
      if (i == 1022) check("fill1_not_full", 32'(bus.buff_full), 32'h0);
    end
    bus.din_valid = 1'b0;
    check("fill1_full", 32'(bus.buff_full), 32'h1);
    check("fill1_cnt", 32'(bus.wr_cnt), 32'd1024);
    check("fill1_no_ovf", 32'(bus.overflow), 32'h0);

    // Sample while FULL is dropped and flags overflow stickily.
    bus.din       = 16'hBEEF;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    check("beef_ovf", 32'(bus.overflow), 32'h1);
    step();
    check("beef_ovf_sticky", 32'(bus.overflow), 32'h1);
    check("beef_still_full", 32'(bus.buff_full), 32'h1);
    check("beef_cnt", 32'(bus.wr_cnt), 32'd1024);

    // Drain frame 1 back-to-back; no 0xBEEF may appear.
    for (int i = 0; i < 1024; i++) begin
      bus.rd_req = 1'b1;
      step();
      check($sformatf("drain1_w%0d", i), 32'(bus.dout), 32'(i));
      check($sformatf("drain1_v%0d", i), 32'(bus.dout_valid), 32'h1);
      if (i == 500)  check("drain1_cnt_hold", 32'(bus.wr_cnt), 32'd1024);
      if (i == 1022) check("drain1_full_before_last", 32'(bus.buff_full), 32'h1);
    end
    bus.rd_req = 1'b0;
    check("drain1_empty", 32'(bus.buff_full), 32'h0);
    check("drain1_cnt0", 32'(bus.wr_cnt), 32'd0);
    step();
    check("idle_valid_low", 32'(bus.dout_valid), 32'h0);
    check("idle_dout_hold", 32'(bus.dout), 32'h3FF);

    // Partial fill of 10, then rd_req in FILL is ignored.
    for (int i = 0; i < 10; i++) begin
      bus.din       = 16'(32'h100 + i);
      bus.din_valid = 1'b1;
      step();
    end
    bus.din_valid = 1'b0;
    check("part_cnt10", 32'(bus.wr_cnt), 32'd10);
    for (int i = 0; i < 5; i++) begin
      bus.rd_req = 1'b1;
      step();
      check($sformatf("fill_rd_ign_v%0d", i), 32'(bus.dout_valid), 32'h0);
    end
    bus.rd_req = 1'b0;
    check("fill_rd_ign_cnt", 32'(bus.wr_cnt), 32'd10);
    check("fill_rd_ign_dout", 32'(bus.dout), 32'h3FF);
    for (int i = 10; i < 1024; i++) begin
      bus.din       = 16'(32'h100 + i);
      bus.din_valid = 1'b1;
      step();
    end
    bus.din_valid = 1'b0;
    check("fill2_full", 32'(bus.buff_full), 32'h1);

    // Drain 300 words from word 0, then reset mid-FULL.
    for (int i = 0; i < 300; i++) begin
      bus.rd_req = 1'b1;
      step();
      check($sformatf("drain2_w%0d", i), 32'(bus.dout), 32'(32'h100 + i));
    end
    bus.rd_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", 32'(bus.dout), 32'h0);
    check("mid_rst_full", 32'(bus.buff_full), 32'h0);
    check("mid_rst_cnt", 32'(bus.wr_cnt), 32'h0);
    check("mid_rst_ovf", 32'(bus.overflow), 32'h0);
    check("mid_rst_valid", 32'(bus.dout_valid), 32'h0);
    step();
    rst_n = 1'b1;

    // Frame 3 with din_valid held high through the whole drain.
    for (int i = 0; i < 1024; i++) begin
      bus.din       = 16'(32'h2000 + i);
      bus.din_valid = 1'b1;
      step();
    end
    check("fill3_full", 32'(bus.buff_full), 32'h1);
    check("fill3_no_ovf", 32'(bus.overflow), 32'h0);
    for (int i = 0; i < 1024; i++) begin
      bus.din    = (i == 1023) ? 16'h7777 : 16'(32'h7000 + i);
      bus.rd_req = 1'b1;
      step();
      check($sformatf("drain3_w%0d", i), 32'(bus.dout), 32'(32'h2000 + i));
      if (i == 0) check("drain3_ovf", 32'(bus.overflow), 32'h1);
    end
    bus.rd_req = 1'b0;
    check("drain3_cnt0", 32'(bus.wr_cnt), 32'd0);
    bus.din = 16'hA5A5;
    step();
    bus.din_valid = 1'b0;
    check("frame4_cnt1", 32'(bus.wr_cnt), 32'd1);
    check("frame4_ovf_sticky", 32'(bus.overflow), 32'h1);
    for (int i = 1; i < 1024; i++) begin
      bus.din       = 16'(32'h3000 + i);
      bus.din_valid = 1'b1;
      step();
    end
    bus.din_valid = 1'b0;
    check("fill4_full", 32'(bus.buff_full), 32'h1);
    bus.rd_req = 1'b1;
    step();
    check("drain4_w0", 32'(bus.dout), 32'hA5A5);
    step();
    check("drain4_w1", 32'(bus.dout), 32'h3001);
    bus.rd_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
